// File: rtl/pcie_tlp_completer.sv
// pcie_tlp_completer: answers single-DW MRd32/MWr32 requests that hit BAR0
// against an internal 2^REG_ADDR_BITS x 32 register bank. MRd32 requests are
// answered with a CplD on the tx stream; MWr32 data is byte-masked into the bank.
//
// Handshake: a beat moves on either AXI-Stream interface only in a cycle where
// tvalid and tready are both high at the rising edge; tx tdata/tlast are held
// until that happens. rx_tready is low for the whole completion.
//
// Optional feature: define PCIE_TLP_COMPLETER_STATS_EN to build the saturating
// stat_rd/stat_wr/stat_drop counters; otherwise they read 16'h0.
module pcie_tlp_completer #(
    parameter int REG_ADDR_BITS = 4
) (
    input  logic        user_clk,
    input  logic        s_aresetn,
    input  logic [7:0]  cfg_bus_number,
    input  logic [4:0]  cfg_device_number,
    input  logic [2:0]  cfg_function_number,
    input  logic [31:0] m_axis_pcie_rx_tdata,
    input  logic        m_axis_pcie_rx_tlast,
    input  logic        m_axis_pcie_rx_tvalid,
    output logic        m_axis_pcie_rx_tready,
    input  logic [21:0] m_axis_pcie_rx_tuser,
    output logic [31:0] s_axis_pcie_tx_tdata,
    output logic [3:0]  s_axis_pcie_tx_tkeep,
    output logic [3:0]  s_axis_pcie_tx_tuser,
    output logic        s_axis_pcie_tx_tlast,
    output logic        s_axis_pcie_tx_tvalid,
    input  logic        s_axis_pcie_tx_tready,
    output logic [15:0] stat_rd,
    output logic [15:0] stat_wr,
    output logic [15:0] stat_drop
);

    localparam int NREG = 1 << REG_ADDR_BITS;

    typedef enum logic [3:0] {
        RX_H0, RX_H1, RX_H2, RX_DATA, DRAIN, TX_H0, TX_H1, TX_H2, TX_D
    } state_t;

    state_t                   state_q, state_d;
    logic                     rx_tready_q, rx_tready_d;
    logic                     tx_valid_q, tx_valid_d;
    logic                     tx_last_q, tx_last_d;
    logic [31:0]              tx_data_q, tx_data_d;
    logic                     is_wr_q, is_wr_d;
    logic [2:0]               tc_q, tc_d;
    logic [1:0]               attr_q, attr_d;
    logic [15:0]              req_id_q, req_id_d;
    logic [7:0]               tag_q, tag_d;
    logic [3:0]               be_q, be_d;
    logic [REG_ADDR_BITS-1:0] idx_q, idx_d;
    logic [4:0]               addr_lo_q, addr_lo_d;
    logic [31:0]              bank_q [NREG];
    logic [31:0]              bank_d [NREG];

    logic rx_fire, tx_fire, hdr_ok;
    logic rd_inc, wr_inc, drop_inc;

    assign rx_fire = m_axis_pcie_rx_tvalid & rx_tready_q;
    assign tx_fire = tx_valid_q & s_axis_pcie_tx_tready;
    assign hdr_ok  = ((m_axis_pcie_rx_tdata[31:24] == 8'h00) ||
                      (m_axis_pcie_rx_tdata[31:24] == 8'h40)) &&
                     (m_axis_pcie_rx_tdata[9:0] == 10'd1) &&
                     m_axis_pcie_rx_tuser[2];

    // Request parse, completion sequencing and bank write: next-state computation
    always_comb begin
        state_d   = state_q;
        tx_valid_d = tx_valid_q;
        tx_last_d = tx_last_q;
        tx_data_d = tx_data_q;
        is_wr_d   = is_wr_q;
        tc_d      = tc_q;
        attr_d    = attr_q;
        req_id_d  = req_id_q;
        tag_d     = tag_q;
        be_d      = be_q;
        idx_d     = idx_q;
        addr_lo_d = addr_lo_q;
        bank_d    = bank_q;
        rd_inc    = 1'b0;
        wr_inc    = 1'b0;
        drop_inc  = 1'b0;
        case (state_q)
            RX_H0: if (rx_fire) begin
                if (hdr_ok && !m_axis_pcie_rx_tlast) begin
                    is_wr_d = m_axis_pcie_rx_tdata[30];
                    tc_d    = m_axis_pcie_rx_tdata[22:20];
                    attr_d  = m_axis_pcie_rx_tdata[13:12];
                    state_d = RX_H1;
                end else begin
                    // Rejected header, or an accepted one that ends too early
                    drop_inc = 1'b1;
                    state_d  = m_axis_pcie_rx_tlast ? RX_H0 : DRAIN;
                end
            end
            RX_H1: if (rx_fire) begin
                if (m_axis_pcie_rx_tlast) begin
                    drop_inc = 1'b1;
                    state_d  = RX_H0;
                end else begin
                    req_id_d = m_axis_pcie_rx_tdata[31:16];
                    tag_d    = m_axis_pcie_rx_tdata[15:8];
                    be_d     = m_axis_pcie_rx_tdata[3:0];
                    state_d  = RX_H2;
                end
            end
            RX_H2: if (rx_fire) begin
                // Upper address bits are ignored, so the bank aliases
                idx_d     = m_axis_pcie_rx_tdata[REG_ADDR_BITS+1:2];
                addr_lo_d = m_axis_pcie_rx_tdata[6:2];
                if (is_wr_q) begin
                    if (m_axis_pcie_rx_tlast) begin
                        drop_inc = 1'b1;
                        state_d  = RX_H0;
                    end else begin
                        state_d = RX_DATA;
                    end
                end else if (m_axis_pcie_rx_tlast) begin
                    tx_valid_d = 1'b1;
                    tx_last_d  = 1'b0;
                    tx_data_d  = {1'b0, 2'b10, 5'b01010, 1'b0, tc_q, 4'b0000,
                                  2'b00, attr_q, 2'b00, 10'd1};
                    state_d    = TX_H0;
                end else begin
                    drop_inc = 1'b1;
                    state_d  = DRAIN;
                end
            end
            RX_DATA: if (rx_fire) begin
                for (int i = 0; i < 4; i++) begin
                    if (be_q[i]) begin
                        bank_d[idx_q][8*i +: 8] = m_axis_pcie_rx_tdata[8*i +: 8];
                    end
                end
                wr_inc  = 1'b1;
                state_d = m_axis_pcie_rx_tlast ? RX_H0 : DRAIN;
            end
            DRAIN: if (rx_fire && m_axis_pcie_rx_tlast) begin
                state_d = RX_H0;
            end
            TX_H0: if (tx_fire) begin
                tx_data_d = {cfg_bus_number, cfg_device_number, cfg_function_number,
                             3'b000, 1'b0, 12'd4};
                state_d   = TX_H1;
            end
            TX_H1: if (tx_fire) begin
                tx_data_d = {req_id_q, tag_q, 1'b0, addr_lo_q, 2'b00};
                state_d   = TX_H2;
            end
            TX_H2: if (tx_fire) begin
                // Byte enables are ignored on reads: always the full DW
                tx_data_d = bank_q[idx_q];
                tx_last_d = 1'b1;
                state_d   = TX_D;
            end
            TX_D: if (tx_fire) begin
                tx_valid_d = 1'b0;
                tx_last_d  = 1'b0;
                tx_data_d  = 32'h0;
                rd_inc     = 1'b1;
                state_d    = RX_H0;
            end
            default: state_d = RX_H0;
        endcase
        rx_tready_d = !(state_d inside {TX_H0, TX_H1, TX_H2, TX_D});
    end

    // State, registered stream outputs, latched header fields and bank
    always_ff @(posedge user_clk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            state_q     <= RX_H0;
            rx_tready_q <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_last_q   <= 1'b0;
            tx_data_q   <= 32'h0;
            is_wr_q     <= 1'b0;
            tc_q        <= 3'h0;
            attr_q      <= 2'h0;
            req_id_q    <= 16'h0;
            tag_q       <= 8'h0;
            be_q        <= 4'h0;
            idx_q       <= '0;
            addr_lo_q   <= 5'h0;
            for (int i = 0; i < NREG; i++) begin
                bank_q[i] <= 32'h0;
            end
        end else begin
            state_q     <= state_d;
            rx_tready_q <= rx_tready_d;
            tx_valid_q  <= tx_valid_d;
            tx_last_q   <= tx_last_d;
            tx_data_q   <= tx_data_d;
            is_wr_q     <= is_wr_d;
            tc_q        <= tc_d;
            attr_q      <= attr_d;
            req_id_q    <= req_id_d;
            tag_q       <= tag_d;
            be_q        <= be_d;
            idx_q       <= idx_d;
            addr_lo_q   <= addr_lo_d;
            for (int i = 0; i < NREG; i++) begin
                bank_q[i] <= bank_d[i];
            end
        end
    end

`ifdef PCIE_TLP_COMPLETER_STATS_EN
    logic [15:0] stat_rd_q, stat_rd_d;
    logic [15:0] stat_wr_q, stat_wr_d;
    logic [15:0] stat_drop_q, stat_drop_d;

    // Saturating event counters
    always_comb begin
        stat_rd_d   = stat_rd_q;
        stat_wr_d   = stat_wr_q;
        stat_drop_d = stat_drop_q;
        if (rd_inc && stat_rd_q != 16'hFFFF)     stat_rd_d   = stat_rd_q + 16'd1;
        if (wr_inc && stat_wr_q != 16'hFFFF)     stat_wr_d   = stat_wr_q + 16'd1;
        if (drop_inc && stat_drop_q != 16'hFFFF) stat_drop_d = stat_drop_q + 16'd1;
    end

    // Counter registers
    always_ff @(posedge user_clk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            stat_rd_q   <= 16'h0;
            stat_wr_q   <= 16'h0;
            stat_drop_q <= 16'h0;
        end else begin
            stat_rd_q   <= stat_rd_d;
            stat_wr_q   <= stat_wr_d;
            stat_drop_q <= stat_drop_d;
        end
    end

    assign stat_rd   = stat_rd_q;
    assign stat_wr   = stat_wr_q;
    assign stat_drop = stat_drop_q;
`else
    logic unused_stat_inc;
    assign unused_stat_inc = rd_inc ^ wr_inc ^ drop_inc;
    assign stat_rd   = 16'h0;
    assign stat_wr   = 16'h0;
    assign stat_drop = 16'h0;
`endif

    logic unused_tuser;
    assign unused_tuser = ^{m_axis_pcie_rx_tuser[21:3], m_axis_pcie_rx_tuser[1:0]};

    assign m_axis_pcie_rx_tready = rx_tready_q;
    assign s_axis_pcie_tx_tdata  = tx_data_q;
    assign s_axis_pcie_tx_tlast  = tx_last_q;
    assign s_axis_pcie_tx_tvalid = tx_valid_q;
    assign s_axis_pcie_tx_tkeep  = 4'hf;
    assign s_axis_pcie_tx_tuser  = 4'h0;

endmodule

// File: doc/pcie_tlp_completer.md
# pcie_tlp_completer

Hardware completer for the Spartan-6 PCI-E endpoint in the `user_clk` domain. It consumes the 32-bit AXI-Stream TLP receive stream from the PCI-E core and answers single-DW memory requests that hit BAR0 against an internal register bank. MRd32 requests get a CplD TLP on the core's transmit stream; MWr32 requests are written into the bank. It is the hardware responder for requests that would otherwise need a round trip through the MicroBlaze FIFO path.

## Interface

- REG_ADDR_BITS, 4, log2 of register count; bank is 2^REG_ADDR_BITS x 32 bit
- user_clk  in  1  PCI-E core user clock; sole clock
- s_aresetn  in  1  asynchronous, active-low reset
- cfg_bus_number  in  8  completer ID bus
- cfg_device_number  in  5  completer ID device
- cfg_function_number  in  3  completer ID function
- m_axis_pcie_rx_tdata  in  32  request TLP DW; fmt/type in [31:24]
- m_axis_pcie_rx_tlast  in  1  last DW of TLP
- m_axis_pcie_rx_tvalid  in  1  rx DW valid
- m_axis_pcie_rx_tready  out  1  rx DW accepted
- m_axis_pcie_rx_tuser  in  22  core rx sideband; [2] = BAR0 hit
- s_axis_pcie_tx_tdata  out  32  completion DW
- s_axis_pcie_tx_tkeep  out  4  constant 4'hf
- s_axis_pcie_tx_tuser  out  4  constant 4'h0
- s_axis_pcie_tx_tlast  out  1  last completion DW
- s_axis_pcie_tx_tvalid  out  1  completion DW valid
- s_axis_pcie_tx_tready  in  1  core accepts DW
- stat_rd  out  16  count of MRd32 requests completed
- stat_wr  out  16  count of MWr32 requests written
- stat_drop  out  16  count of TLPs dropped

## Operation

- States: RX_H0, RX_H1, RX_H2, RX_DATA, DRAIN, TX_H0, TX_H1, TX_H2, TX_D.
- RX_H0: decode byte [31:24]. The request is accepted only if:
  - it is 8'h00 (MRd32) or 8'h40 (MWr32),
  - length [9:0] is 1,
  - tuser[2] is 1.
  - Latch TC [22:20] and attr [13:12]. Go to RX_H1.
  - Otherwise mark the TLP dropped and go to DRAIN. If tlast is set, go to RX_H0 instead.
- RX_H1: latch requester ID [31:16], tag [15:8], first BE [3:0].
- RX_H2: latch address [31:2]. Register index is addr[REG_ADDR_BITS+1:2]; upper bits are ignored (aliasing).
  - MRd32 with tlast: go to TX_H0.
  - MWr32: go to RX_DATA.
  - MRd32 without tlast (malformed): go to DRAIN.
- RX_DATA: write the data DW, byte-masked by first BE. Byte lane i = tdata[8i+7:8i], BE bit i. Go to RX_H0 if tlast, else DRAIN.
- DRAIN: accept and discard beats until tlast, then go to RX_H0.
- tlast seen in RX_H0 (for an accepted TLP), RX_H1, or RX_H2 before the expected end: abort to RX_H0, count as drop, perform no write and no completion.
- Completion TLP, DW0..DW3:
  - DW0: {1'b0, 2'b10, 5'b01010, 1'b0, TC, 4'b0, 2'b00, attr, 2'b00, 10'd1}.
  - DW1: {bus, dev, func, 3'b000 status, 1'b0 BCM, 12'd4}.
  - DW2: {requester ID, tag, 1'b0, addr[6:2], 2'b00}.
  - DW3: register value.
  - MRd ignores BE and always returns the full DW.
- Register bank and all latched fields reset to 0.

## Timing

- m_axis_pcie_rx_tready = 1 in RX_H0/RX_H1/RX_H2/RX_DATA/DRAIN, 0 in TX states. Only one request is in flight.
- A beat transfers on tvalid & tready, on both interfaces. The tx DW and tlast stay stable until tready.
- Latency: TX_H0 tvalid is asserted the cycle after the MRd DW2 beat is accepted. The completion takes at least 4 cycles. tlast is set only on DW3.
- rx_tready returns the cycle after the DW3 handshake.
- An MWr register update is visible to an MRd whose DW2 is accepted one or more cycles after the data beat.
- Counters increment the cycle after the deciding beat and saturate at 16'hFFFF.
- Reset values: tx_tvalid 0, tx_tlast 0, tx_tdata 0, rx_tready 0 while reset is asserted, state RX_H0, stats 0.
- Reset asserted mid-completion: tvalid drops immediately (asynchronous) and the partial TLP is abandoned.

## Configuration

- PCIE_TLP_COMPLETER_STATS_EN defined: stat_rd/stat_wr/stat_drop are live saturating counters.
- Not defined: the counters are not built and all three stat outputs are tied to 16'h0. All other behaviour is identical.

## Test plan

- MWr32 to addr 0x0000_0008 (tuser[2]=1), BE 4'hF, data 0xDEADBEEF; then MRd32 addr 0x08, tag 0x5A, req ID 0x0100, bus 1, dev 0, func 0 -> CplD 0x4A000001, 0x01000004, 0x01005A08, 0xDEADBEEF; tlast on the 4th DW.
- MWr32 to addr 0x08 with BE 4'b0011, data 0x11223344 over stored 0xDEADBEEF -> readback 0xDEAD3344.
- tx_tready held 0 for 5 cycles during DW1 -> DW1 stable, rx_tready 0 throughout, completion finishes after tready rises.
- MRd32 with length 2, and a 4DW-header MRd (byte 0x20) -> no tx activity, all beats drained, stat_drop = 2.
- MRd32 with tuser[2]=0 -> dropped; MWr to addr 0x48 with REG_ADDR_BITS=4 -> aliases register 2, readback at 0x08 matches.
- Assert s_aresetn=0 during TX_H2 -> tvalid 0 immediately; after release, a new MRd to addr 0x08 returns 0x00000000.
